// File: rtl/regfile_wb_queue_if.sv
// Bus bundle between write-request producers/drain control and the write-back queue.
// Master drives requests, drain enable and lookup address; slave is the queue.
interface regfile_wb_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REG = 32,
  parameter int unsigned N_SRC = 2,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(N_REG);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N_SRC-1:0]            src_valid;
  logic [N_SRC-1:0]            src_ready;
  logic [N_SRC-1:0][AW-1:0]    src_addr;
  logic [N_SRC-1:0][WIDTH-1:0] src_data;
  logic                        drain_en;
  logic                        wen;
  logic [AW-1:0]               waddr;
  logic [WIDTH-1:0]            wdata;
  logic [CW-1:0]               count;
  logic                        full;
  logic                        empty;
  logic [AW-1:0]               q_addr;
  logic                        q_hit;
  logic [WIDTH-1:0]            q_data;

  modport master (
    output src_valid, src_addr, src_data, drain_en, q_addr,
    input  src_ready, wen, waddr, wdata, count, full, empty, q_hit, q_data
  );

  modport slave (
    input  src_valid, src_addr, src_data, drain_en, q_addr,
    output src_ready, wen, waddr, wdata, count, full, empty, q_hit, q_data
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Round-robin write-back queue feeding one register-file write port.
// Define REGFILE_WBQ_FWD_EN to enable the queued-data forwarding lookup (q_hit/q_data).
module regfile_wb_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REG = 32,
  parameter int unsigned N_SRC = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_queue_if.slave    bus
);
  localparam int unsigned AW = $clog2(N_REG);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;

  logic             full, empty, pop, push;
  logic [N_SRC-1:0] grant, ready;
  logic [SW-1:0]    win;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = bus.drain_en & ~empty;

  always_comb begin
    grant = '0;
    win   = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (grant == '0 && bus.src_valid[(int'(rr_ptr_q) + k) % int'(N_SRC)]) begin
        grant[(int'(rr_ptr_q) + k) % int'(N_SRC)] = 1'b1;
        win = SW'((int'(rr_ptr_q) + k) % int'(N_SRC));
      end
    end
    // Held low while reset is asserted so nothing looks accepted mid-reset.
    ready = grant & {N_SRC{(~full | pop) & ~rst}};
    push  = |ready;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rr_ptr_d = push ? SW'((int'(win) + 1) % int'(N_SRC)) : rr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Clear before set: when full, push and pop hit the same slot.
    vld_d = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.src_addr[win];
      data_q[wr_ptr_q] <= bus.src_data[win];
    end
  end

  assign bus.src_ready = ready;
  assign bus.wen       = pop;
  assign bus.waddr     = addr_q[rd_ptr_q];
  assign bus.wdata     = data_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

`ifdef REGFILE_WBQ_FWD_EN
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (vld_q[rd_ptr_q + PW'(k)] && addr_q[rd_ptr_q + PW'(k)] == bus.q_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  assign bus.q_hit  = fwd_hit;
  assign bus.q_data = fwd_data;
`else
  assign bus.q_hit  = 1'b0;
  assign bus.q_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (default parameters).
module tb_regfile_wb_queue;
  logic clk;
  logic rst;
  int   nchecks = 0;
  int   nerrors = 0;

  regfile_wb_queue_if bus ();

  regfile_wb_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [4:0] a, input logic [31:0] d);
    bus.src_addr[s] = a;
    bus.src_data[s] = d;
  endtask

`ifdef REGFILE_WBQ_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic [1:0]  rr_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic        rr_wen [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] rr_dat [4] = '{32'h0, 32'h20, 32'h10, 32'h20};

  initial begin
    rst           = 1'b1;
    bus.src_valid = 2'b11;
    bus.src_addr  = '0;
    bus.src_data  = '0;
    bus.drain_en  = 1'b1;
    bus.q_addr    = '0;
    #13;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_wen", 64'(bus.wen), 64'd0);
    chk("rst_ready", 64'(bus.src_ready), 64'd0);
    chk("rst_qhit", 64'(bus.q_hit), 64'd0);
    chk("rst_qdata", 64'(bus.q_data), 64'd0);
    bus.src_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single path: accept at edge t, write visible in cycle t+1.
    bus.src_valid = 2'b01;
    set_src(0, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("single_ready", 64'(bus.src_ready), 64'h1);
    chk("single_no_bypass", 64'(bus.wen), 64'd0);
    tick();
    bus.src_valid = 2'b00;
    #1;
    chk("single_wen", 64'(bus.wen), 64'd1);
    chk("single_waddr", 64'(bus.waddr), 64'd5);
    chk("single_wdata", 64'(bus.wdata), 64'hDEAD_BEEF);
    chk("single_count", 64'(bus.count), 64'd1);
    tick();
    chk("single_drained", 64'(bus.count), 64'd0);
    chk("single_idle_wen", 64'(bus.wen), 64'd0);

    // Round-robin: rr pointer is 1 after src0 was served.
    bus.src_valid = 2'b11;
    set_src(0, 5'd1, 32'h10);
    set_src(1, 5'd2, 32'h20);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(bus.src_ready), 64'(rr_exp[i]));
      chk($sformatf("rr_wen%0d", i), 64'(bus.wen), 64'(rr_wen[i]));
      if (rr_wen[i]) chk($sformatf("rr_wdata%0d", i), 64'(bus.wdata), 64'(rr_dat[i]));
      tick();
    end
    bus.src_valid = 2'b10;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rr_src1_only%0d", i), 64'(bus.src_ready), 64'h2);
      tick();
    end
    chk("rr_count", 64'(bus.count), 64'd1);
    bus.src_valid = 2'b00;
    tick();
    chk("rr_empty", 64'(bus.empty), 64'd1);

    // Fill to full with drain disabled.
    bus.drain_en  = 1'b0;
    bus.src_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      set_src(0, 5'(i), 32'h100 + 32'(i));
      #1;
      chk($sformatf("fill_ready%0d", i), 64'(bus.src_ready), 64'h1);
      tick();
    end
    set_src(0, 5'd4, 32'h104);
    #1;
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_backpressure", 64'(bus.src_ready), 64'h0);
    bus.drain_en = 1'b1;
    #1;
    chk("full_push_pop_ready", 64'(bus.src_ready), 64'h1);
    chk("full_pop_wdata", 64'(bus.wdata), 64'h100);
    tick();
    bus.src_valid = 2'b00;
    #1;
    chk("full_count_held", 64'(bus.count), 64'd4);
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("order_wen%0d", j), 64'(bus.wen), 64'd1);
      chk($sformatf("order_waddr%0d", j), 64'(bus.waddr), 64'(j));
      chk($sformatf("order_wdata%0d", j), 64'(bus.wdata), 64'h100 + 64'(j));
      tick();
    end
    chk("full_drained", 64'(bus.empty), 64'd1);

    // Same address twice: FIFO order preserved.
    bus.drain_en  = 1'b0;
    bus.src_valid = 2'b01;
    set_src(0, 5'd3, 32'd1);
    tick();
    set_src(0, 5'd3, 32'd2);
    tick();
    bus.src_valid = 2'b00;
    bus.drain_en  = 1'b1;
    #1;
    chk("same_addr_a", 64'(bus.waddr), 64'd3);
    chk("same_addr_first", 64'(bus.wdata), 64'd1);
    tick();
    chk("same_addr_second", 64'(bus.wdata), 64'd2);
    tick();
    chk("same_addr_empty", 64'(bus.empty), 64'd1);

    // Forwarding lookup with two writes to r7, then a third entry.
    bus.drain_en  = 1'b0;
    bus.src_valid = 2'b01;
    set_src(0, 5'd7, 32'hA);
    tick();
    set_src(0, 5'd7, 32'hB);
    tick();
    set_src(0, 5'd9, 32'hC);
    bus.q_addr = 5'd7;
    #1;
    chk("fwd_hit7", 64'(bus.q_hit), 64'(Fwd));
    chk("fwd_data7", 64'(bus.q_data), Fwd ? 64'hB : 64'h0);
    chk("fwd_exclude_push", 64'(bus.src_ready), 64'h1);
    bus.q_addr = 5'd9;
    #1;
    chk("fwd_pending_not_searched", 64'(bus.q_hit), 64'd0);
    bus.q_addr = 5'd8;
    #1;
    chk("fwd_miss8", 64'(bus.q_hit), 64'd0);
    chk("fwd_miss8_data", 64'(bus.q_data), 64'd0);
    tick();
    bus.src_valid = 2'b00;
    bus.q_addr    = 5'd7;
    bus.drain_en  = 1'b1;
    #1;
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    chk("fwd_head_popping", 64'(bus.q_hit), 64'(Fwd));

    // Asynchronous reset mid-run discards three queued entries.
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_wen", 64'(bus.wen), 64'd0);
    chk("arst_qhit", 64'(bus.q_hit), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_wen", 64'(bus.wen), 64'd0);
    tick();
    chk("post_rst_wen_edge", 64'(bus.wen), 64'd0);
    chk("post_rst_empty", 64'(bus.empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
